// File: rtl/grid_pkg.sv
// Shared types and default dimensions for the grid diff scanner.
package grid_pkg;

  localparam int DEF_GRID_W = 16;
  localparam int DEF_GRID_H = 12;
  localparam int DEF_CODE_W = 3;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    HEAD   = 3'd1,
    BODY   = 3'd2,
    APPLE  = 3'd3,
    BORDER = 3'd4
  } obj_code_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT_CMD,
    DONE
  } scan_state_t;

endpackage

// File: rtl/grid_shadow_mem.sv
// Shadow copy of the drawn grid: comb read, 1-cycle write, sync clear.
module grid_shadow_mem
  import grid_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int CODE_W = DEF_CODE_W,
  parameter int AW     = $clog2(GRID_W*GRID_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [CODE_W-1:0] wdata_i,
  output logic [CODE_W-1:0] rdata_o
);

  localparam int DEPTH = GRID_W * GRID_H;

  logic [CODE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/grid_diff_scanner.sv
// Frame scanner: emits changed cells (or all cells on init passes).
module grid_diff_scanner
  import grid_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int CODE_W = DEF_CODE_W,
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H),
  parameter int CW     = $clog2(GRID_W*GRID_H+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              clear_req,
  input  logic [CODE_W-1:0] obj_in,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic              upd_valid,
  output logic [CODE_W-1:0] obj_code,
  input  logic              cmd_done,
  output logic              init_cycle,
  output logic              busy,
  output logic              frame_done,
  output logic [CW-1:0]     upd_count
);

  localparam int AW = $clog2(GRID_W*GRID_H);

  scan_state_t       state_q, state_d;
  logic [XW-1:0]     x_q, x_d, x_nxt;
  logic [YW-1:0]     y_q, y_d, y_nxt;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CW-1:0]     tally_q, tally_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              init_q, init_d;
  logic              rsp_q, rsp_d;
  logic              mem_we;
  logic [AW-1:0]     addr;
  logic [CODE_W-1:0] shadow;
  logic              x_end, last, diff;

  assign addr  = AW'(y_q) * AW'(GRID_W) + AW'(x_q);
  assign x_end = (x_q == XW'(GRID_W-1));
  assign last  = x_end && (y_q == YW'(GRID_H-1));
  assign diff  = (obj_in != shadow) || init_q;

  grid_shadow_mem #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .CODE_W (CODE_W),
    .AW     (AW)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clear_req),
    .we_i    (mem_we),
    .addr_i  (addr),
    .wdata_i (obj_in),
    .rdata_o (shadow)
  );

  always_comb begin
    x_nxt = x_q + XW'(1);
    y_nxt = y_q;
    unique case (1'b1)
      last:           begin x_nxt = '0; y_nxt = '0; end
      x_end && !last: begin x_nxt = '0; y_nxt = y_q + YW'(1); end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    code_d  = code_q;
    tally_d = tally_q;
    cnt_d   = cnt_q;
    init_d  = init_q | clear_req;
    rsp_d   = rsp_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tally_d = '0;
        x_d     = '0;
        y_d     = '0;
        if (frame_start) state_d = SCAN;
      end
      SCAN: begin
        if (clear_req) begin
          x_d     = '0;
          y_d     = '0;
          tally_d = '0;
        end else if (diff) begin
          code_d  = obj_in;
          mem_we  = 1'b1;
          state_d = WAIT_CMD;
        end else begin
          x_d = x_nxt;
          y_d = y_nxt;
          if (last) state_d = DONE;
        end
      end
      WAIT_CMD: begin
        if (clear_req) rsp_d = 1'b1;
        if (cmd_done) begin
          // a clear seen during the wait restarts the pass once drawn
          if (rsp_q || clear_req) begin
            x_d     = '0;
            y_d     = '0;
            tally_d = '0;
            rsp_d   = 1'b0;
            state_d = SCAN;
          end else begin
            tally_d = tally_q + CW'(1);
            x_d     = x_nxt;
            y_d     = y_nxt;
            state_d = last ? DONE : SCAN;
          end
        end
      end
      DONE: begin
        cnt_d   = tally_q;
        init_d  = clear_req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      code_q  <= '0;
      tally_q <= '0;
      cnt_q   <= '0;
      init_q  <= 1'b1;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      code_q  <= code_d;
      tally_q <= tally_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      rsp_q   <= rsp_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign obj_code   = code_q;
  assign upd_valid  = (state_q == WAIT_CMD);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign init_cycle = init_q;
  assign upd_count  = cnt_q;

endmodule

// File: tb/tb_grid_diff_scanner.sv
// Self-checking bench for grid_diff_scanner with a frame-level model.
module tb_grid_diff_scanner;
  import grid_pkg::*;

  localparam int W = 16;
  localparam int H = 12;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       clear_req = 1'b0;
  logic       cmd_done = 1'b0;
  logic [2:0] obj_in;
  logic [2:0] obj_code;
  logic [3:0] x;
  logic [3:0] y;
  logic       upd_valid, init_cycle, busy, frame_done;
  logic [7:0] upd_count;

  int map [N];
  int shm [N];
  bit initm;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;
    int ex[3];
    int ey[3];
    int ec[3];
    int dly;
    int exp_cnt;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  always_comb begin
    obj_in = 3'd0;
    if (int'(y) * W + int'(x) < N) obj_in = 3'(map[int'(y) * W + int'(x)]);
  end

  grid_diff_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .clear_req   (clear_req),
    .obj_in      (obj_in),
    .x           (x),
    .y           (y),
    .upd_valid   (upd_valid),
    .obj_code    (obj_code),
    .cmd_done    (cmd_done),
    .init_cycle  (init_cycle),
    .busy        (busy),
    .frame_done  (frame_done),
    .upd_count   (upd_count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) shm[i] = 0;
    initm = 1'b1;
  endtask

  function automatic int cur_cell();
    return int'(y) * W + int'(x);
  endfunction

  // Runs one pass to frame_done, answering each update after dly cycles.
  task automatic run_frame(input bit start, input int dly, output int fd);
    int expq[$];
    int gotq[$];
    int w, cyc, hcell, hc, ncell;
    bit pend, after;
    for (int i = 0; i < N; i++) begin
      if (initm || map[i] != shm[i]) begin
        expq.push_back(i * 8 + map[i]);
        shm[i] = map[i];
      end
    end
    initm = 1'b0;
    fd = -1; pend = 0; after = 0; w = 0;
    hcell = 0; hc = 0; ncell = 0;
    if (start) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    cyc = 1;
    while (cyc < 20000) begin
      cmd_done = 1'b0;
      if (after) begin
        chk("resume_valid", upd_valid, 0);
        chk("resume_cell", cur_cell(), ncell);
        after = 0;
      end
      if (frame_done) begin
        fd = cyc;
        break;
      end
      if (upd_valid) begin
        if (!pend) begin
          pend = 1; w = 0;
          hcell = cur_cell(); hc = int'(obj_code);
          gotq.push_back(hcell * 8 + hc);
        end else begin
          chk("hold_cell", cur_cell() * 8 + int'(obj_code), hcell * 8 + hc);
        end
        if (w == dly - 1) begin
          cmd_done = 1'b1;
          pend = 0; after = 1;
          ncell = (hcell + 1) % N;
        end
        w++;
      end
      @(negedge clk);
      cyc++;
    end
    if (fd < 0) chk("frame_timeout", 0, 1);
    chk("upd_total", gotq.size(), expq.size());
    for (int i = 0; i < gotq.size() && i < expq.size(); i++)
      chk("upd_cell", gotq[i], expq[i]);
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 0);
    chk("idle_after", busy, 0);
    chk("init_after", init_cycle, 0);
    chk("upd_count", upd_count, expq.size());
  endtask

  initial begin
    int fd, k, c, n;
    tbl[0] = '{3, '{4, 5, 6}, '{4, 4, 4}, '{1, 2, 3}, 2, 3};
    tbl[1] = '{1, '{8, 0, 0}, '{4, 0, 0}, '{2, 0, 0}, 50, 1};
    tbl[2] = '{1, '{4, 0, 0}, '{4, 0, 0}, '{0, 0, 0}, 1, 1};
    tbl[3] = '{0, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, 1, 0};
    for (int i = 0; i < N; i++) map[i] = 0;
    model_clear();

    repeat (3) @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_valid", upd_valid, 0);
    chk("rst_code", obj_code, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_count", upd_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init", init_cycle, 1);
    rst = 1'b0;
    @(negedge clk);

    run_frame(1, 2, fd);
    run_frame(1, 2, fd);
    chk("nodiff_latency", fd, N + 1);

    for (int t = 0; t < 4; t++) begin
      for (int e = 0; e < tbl[t].n; e++)
        map[tbl[t].ey[e] * W + tbl[t].ex[e]] = tbl[t].ec[e];
      run_frame(1, tbl[t].dly, fd);
      chk("tbl_count", upd_count, tbl[t].exp_cnt);
    end

    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k = 0;
    while (cur_cell() != 3 * W + 7 && k < 1000) begin
      if (frame_done) chk("abort_early_done", frame_done, 0);
      @(negedge clk);
      k++;
    end
    chk("abort_reach", k < 1000, 1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("abort_restart", cur_cell(), 0);
    chk("abort_init", init_cycle, 1);
    chk("abort_no_done", frame_done, 0);
    chk("abort_busy", busy, 1);
    model_clear();
    run_frame(0, 1, fd);

    map[2] = 4;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k = 0;
    while (!upd_valid && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("coinc_cell", cur_cell() * 8 + int'(obj_code), 2 * 8 + 4);
    @(negedge clk);
    cmd_done = 1'b1;
    clear_req = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    clear_req = 1'b0;
    chk("coinc_valid", upd_valid, 0);
    chk("coinc_restart", cur_cell(), 0);
    chk("coinc_init", init_cycle, 1);
    model_clear();
    run_frame(0, 1, fd);
    chk("coinc_count", upd_count, N);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 5);
      for (int e = 0; e < n; e++) begin
        c = $urandom_range(0, N - 1);
        map[c] = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 2) == 0) begin
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("idle_clear_init", init_cycle, 1);
        model_clear();
      end
      run_frame(1, $urandom_range(1, 4), fd);
    end

    map[5] = (map[5] + 1) % 5;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k = 0;
    while (!upd_valid && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("mrst_pending", upd_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", upd_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_init", init_cycle, 1);
    chk("mrst_code", obj_code, 0);
    chk("mrst_count", upd_count, 0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    run_frame(1, 1, fd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
